// File: rtl/sme_stream_loader.sv
// sme_stream_loader: upstream feeder for the string-matching engine (SME).
// Buffers tagged byte records (string / pattern) in a FIFO and replays them
// to the SME one character per cycle with isstring/ispattern framing, then
// waits for the SME result before releasing further traffic.
// Optional build macro: SME_LDR_TIMEOUT_EN adds a WAIT_RES timeout counter.
module sme_stream_loader #(
    parameter int DEPTH   = 64,
    parameter int STR_MAX = 32,
    parameter int PAT_MAX = 8,
    parameter int TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_data,
    input  logic       in_type,
    input  logic       in_last,
    input  logic       sme_valid,
    output logic [7:0] chardata,
    output logic       isstring,
    output logic       ispattern,
    output logic       busy,
    output logic       err
);
    localparam int AW   = $clog2(DEPTH);
    localparam int LMAX = (STR_MAX > PAT_MAX) ? STR_MAX : PAT_MAX;
    localparam int LW   = $clog2(LMAX + 1);
    localparam logic [LW-1:0] STR_LIM = LW'(STR_MAX);
    localparam logic [LW-1:0] PAT_LIM = LW'(PAT_MAX);
    localparam logic [LW-1:0] LEN_ONE = LW'(1);
    localparam logic [AW:0]   PTR_ONE = (AW+1)'(1);
    localparam logic [AW:0]   CNT_TWO = (AW+1)'(2);
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] SEND     = 2'd1;
    localparam logic [1:0] GAP      = 2'd2;
    localparam logic [1:0] WAIT_RES = 2'd3;

    // Character storage: {type, last, data}
    logic [9:0]    mem [DEPTH];
    // Per-record descriptors (type and stored length), one per complete record,
    // so the read side knows record boundaries without a combinational RAM read.
    logic          desc_type [DEPTH];
    logic [LW-1:0] desc_len  [DEPTH];

    logic [AW:0]   wr_ptr_reg, rd_ptr_reg;
    logic [AW-1:0] dwr_ptr_reg, drd_ptr_reg;
    logic [AW:0]   rec_cnt_reg;
    logic [AW:0]   fill;
    logic          fifo_full;

    // Input side
    logic [LW-1:0] len_cnt_reg, len_inc, len_lim;
    logic          drop_reg, first_drop_reg;
    logic          accept, stored_last, wr_en, desc_push, trunc_err;

    // Read side
    logic [1:0]    state_reg;
    logic [LW-1:0] rem_reg;
    logic          type_reg, drain_reg, have_str_reg;
    logic          frame_reg, err_reg;
    logic [9:0]    rd_data_reg;
    logic          unused_last;

    logic          head_type, next_type;
    logic [LW-1:0] head_len, next_len;
    logic [AW-1:0] next_idx;
    logic          start_send, start_drain;
    logic [LW-1:0] cur_rem;
    logic          cur_type, cur_drain;
    logic          pop, last_pop;
    logic          timeout_hit;

    assign fill      = wr_ptr_reg - rd_ptr_reg;
    assign fifo_full = (fill == FULL_CNT);
    assign in_ready  = !fifo_full && !reset;

    assign accept      = in_valid && in_ready;
    assign len_lim     = in_type ? PAT_LIM : STR_LIM;
    assign len_inc     = len_cnt_reg + LEN_ONE;
    assign stored_last = in_last || (len_inc == len_lim);
    assign wr_en       = accept && !drop_reg;
    assign desc_push   = wr_en && stored_last;
    assign trunc_err   = accept && drop_reg && first_drop_reg;

    // Storage writes; no reset so the arrays map onto block RAM
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_reg[AW-1:0]] <= {in_type, stored_last, in_data};
        end
        if (desc_push) begin
            desc_type[dwr_ptr_reg] <= in_type;
            desc_len[dwr_ptr_reg]  <= len_inc;
        end
    end

    // Write pointers, record count and the truncation/drop tracker
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_reg     <= '0;
            dwr_ptr_reg    <= '0;
            rec_cnt_reg    <= '0;
            len_cnt_reg    <= '0;
            drop_reg       <= 1'b0;
            first_drop_reg <= 1'b0;
        end else begin
            if (wr_en)     wr_ptr_reg  <= wr_ptr_reg + PTR_ONE;
            if (desc_push) dwr_ptr_reg <= dwr_ptr_reg + AW'(1);
            rec_cnt_reg <= rec_cnt_reg + (AW+1)'(desc_push) - (AW+1)'(last_pop);
            if (accept) begin
                if (drop_reg) begin
                    first_drop_reg <= 1'b0;
                    if (in_last) drop_reg <= 1'b0;
                end else if (stored_last) begin
                    len_cnt_reg <= '0;
                    if (!in_last) begin
                        drop_reg       <= 1'b1;
                        first_drop_reg <= 1'b1;
                    end
                end else begin
                    len_cnt_reg <= len_inc;
                end
            end
        end
    end

    assign head_type = desc_type[drd_ptr_reg];
    assign head_len  = desc_len[drd_ptr_reg];
    assign next_idx  = drd_ptr_reg + AW'(1);
    assign next_type = desc_type[next_idx];
    assign next_len  = desc_len[next_idx];

    // Decide whether the head record is sent, discarded, or left waiting
    always_comb begin
        start_send  = 1'b0;
        start_drain = 1'b0;
        if (state_reg == IDLE && rec_cnt_reg != '0) begin
            if (!head_type) begin
                if (rec_cnt_reg >= CNT_TWO) begin
                    if (next_type) start_send  = 1'b1;
                    else           start_drain = 1'b1;
                end
            end else begin
                if (have_str_reg) start_send  = 1'b1;
                else              start_drain = 1'b1;
            end
        end
    end

    // Current record context: from the descriptor on the first pop, then held
    always_comb begin
        if (state_reg == SEND) begin
            cur_rem   = rem_reg;
            cur_type  = type_reg;
            cur_drain = drain_reg;
        end else begin
            cur_rem   = head_len;
            cur_type  = head_type;
            cur_drain = start_drain;
        end
    end

    assign pop      = start_send || start_drain || (state_reg == SEND);
    assign last_pop = pop && (cur_rem == LEN_ONE);

`ifdef SME_LDR_TIMEOUT_EN
    logic [7:0] to_cnt_reg;

    // Cycles spent in WAIT_RES without a result
    always_ff @(posedge clk) begin
        if (reset || state_reg != WAIT_RES) begin
            to_cnt_reg <= '0;
        end else if (!timeout_hit) begin
            to_cnt_reg <= to_cnt_reg + 8'd1;
        end
    end

    assign timeout_hit = (state_reg == WAIT_RES) && !sme_valid &&
                         (to_cnt_reg == 8'(TIMEOUT - 1));
`else
    logic [7:0] unused_timeout;
    assign unused_timeout = 8'(TIMEOUT);
    assign timeout_hit    = 1'b0;
`endif

    // Registered read of the head entry; it becomes chardata one cycle later
    always_ff @(posedge clk) begin
        if (pop) rd_data_reg <= mem[rd_ptr_reg[AW-1:0]];
    end

    // Sequencer: replays string then pattern back-to-back, gap, wait for result
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= IDLE;
            rd_ptr_reg   <= '0;
            drd_ptr_reg  <= '0;
            rem_reg      <= '0;
            type_reg     <= 1'b0;
            drain_reg    <= 1'b0;
            have_str_reg <= 1'b0;
            frame_reg    <= 1'b0;
            err_reg      <= 1'b0;
        end else begin
            frame_reg <= pop && !cur_drain;
            err_reg   <= trunc_err || start_drain || timeout_hit;
            if (pop)      rd_ptr_reg  <= rd_ptr_reg + PTR_ONE;
            if (last_pop) drd_ptr_reg <= drd_ptr_reg + AW'(1);
            if (pop && !cur_drain && !cur_type) have_str_reg <= 1'b1;
            case (state_reg)
                IDLE, SEND: begin
                    if (pop) begin
                        if (!last_pop) begin
                            state_reg <= SEND;
                            rem_reg   <= cur_rem - LEN_ONE;
                            type_reg  <= cur_type;
                            drain_reg <= cur_drain;
                        end else if (cur_drain) begin
                            state_reg <= IDLE;
                            drain_reg <= 1'b0;
                        end else if (!cur_type) begin
                            // No idle cycle between string and pattern
                            state_reg <= SEND;
                            rem_reg   <= next_len;
                            type_reg  <= 1'b1;
                            drain_reg <= 1'b0;
                        end else begin
                            state_reg <= GAP;
                        end
                    end
                end
                GAP: state_reg <= WAIT_RES;
                default: begin
                    if (sme_valid) begin
                        state_reg <= IDLE;
                    end else if (timeout_hit) begin
                        state_reg    <= IDLE;
                        have_str_reg <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign unused_last = rd_data_reg[8];
    assign chardata    = frame_reg ? rd_data_reg[7:0] : 8'd0;
    assign isstring    = frame_reg && !rd_data_reg[9];
    assign ispattern   = frame_reg && rd_data_reg[9];
    assign busy        = (state_reg != IDLE);
    assign err         = err_reg;
endmodule

// File: tb/tb_sme_stream_loader.sv
// tb_sme_stream_loader: directed bench for sme_stream_loader with a scoreboard
// of expected SME characters; optional timeout test under SME_LDR_TIMEOUT_EN.
module tb_sme_stream_loader;
    logic       clk = 1'b0;
    logic       reset, in_valid, in_type, in_last, sme_valid;
    logic [7:0] in_data;
    logic       in_ready, isstring, ispattern, busy, err;
    logic [7:0] chardata;

    always #5 clk = ~clk;

    sme_stream_loader dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_type(in_type), .in_last(in_last),
        .sme_valid(sme_valid), .chardata(chardata), .isstring(isstring),
        .ispattern(ispattern), .busy(busy), .err(err)
    );

    typedef struct packed {
        logic [7:0] d;
        logic       t;
        logic       l;
    } ent_t;

    int         checks = 0;
    int         errors = 0;
    logic [9:0] sb[$];            // {isstring, ispattern, chardata}
    bit         prev_str = 0, prev_pat = 0, gap_seen = 0, gap_evt = 0;
    bit         auto_resp = 0;
    int         err_cnt = 0;
    int         resp_cnt = 0;
    ent_t       fill_q[$];
    int         rec_len[6] = '{20, 4, 20, 4, 24, 2};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic monitor();
        logic [9:0] exp;
        gap_evt = 0;
        if (isstring || ispattern) begin
            check("sb_has_entry", (sb.size() != 0), 1);
            if (sb.size() != 0) begin
                exp = sb.pop_front();
                check("sme_char", {isstring, ispattern, chardata}, exp);
            end
        end
        if (prev_str) check("no_idle_after_string", (isstring || ispattern), 1);
        if (prev_pat && !isstring && !ispattern) begin
            gap_seen = 1;
            gap_evt  = 1;
        end
        if (err) err_cnt++;
        prev_str = isstring;
        prev_pat = ispattern;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        monitor();
        if (resp_cnt > 0) begin
            resp_cnt--;
            sme_valid = (resp_cnt == 0);
        end else begin
            sme_valid = 0;
        end
        if (auto_resp && gap_evt) resp_cnt = 3;
    endtask

    task automatic put(input logic [7:0] d, input logic t, input logic l, input bit exp_out);
        int guard = 0;
        in_valid = 1; in_data = d; in_type = t; in_last = l;
        while (!in_ready && guard < 2000) begin
            step();
            guard++;
        end
        if (!in_ready) check("in_ready_wait", in_ready, 1);
        if (exp_out) sb.push_back({~t, t, d});
        step();
    endtask

    task automatic wait_gap(input string tag);
        int g = 0;
        while (!gap_seen && g < 500) begin
            step();
            g++;
        end
        check(tag, gap_seen, 1);
    endtask

    task automatic wait_done(input string tag);
        int g = 0;
        repeat (3) step();
        while ((busy || sb.size() != 0) && g < 3000) begin
            step();
            g++;
        end
        check({tag, "_busy"}, busy, 0);
        check({tag, "_sb_empty"}, sb.size(), 0);
    endtask

    task automatic do_reset();
        reset = 1;
        sb.delete();
        prev_str = 0; prev_pat = 0; resp_cnt = 0;
        step();
        step();
        reset = 0;
    endtask

    initial begin
        int k, accepted, g;
        bit full_seen;
        reset = 1; in_valid = 0; in_data = 8'd0; in_type = 0; in_last = 0; sme_valid = 0;
        #1;
        check("reset_in_ready_low", in_ready, 0);
        step();
        step();
        check("reset_chardata", chardata, 0);
        check("reset_isstring", isstring, 0);
        check("reset_ispattern", ispattern, 0);
        check("reset_busy", busy, 0);
        check("reset_err", err, 0);
        reset = 0;
        #1;
        check("post_reset_in_ready", in_ready, 1);

        // String "abc" then pattern "b." back-to-back; manual result
        auto_resp = 0; gap_seen = 0; err_cnt = 0;
        put("a", 0, 0, 1); put("b", 0, 0, 1); put("c", 0, 1, 1);
        put("b", 1, 0, 1); put(".", 1, 1, 1);
        in_valid = 0;
        wait_gap("t1_gap");
        check("t1_sb_drained", sb.size(), 0);
        check("t1_busy_waiting", busy, 1);
        repeat (5) step();
        check("t1_busy_still", busy, 1);
        sme_valid = 1;
        step();
        check("t1_busy_after_result", busy, 0);
        check("t1_no_err", err_cnt, 0);

        // Second pattern without resending the string
        auto_resp = 1; gap_seen = 0;
        put("^", 1, 0, 1); put("c", 1, 1, 1);
        in_valid = 0;
        wait_done("t2");
        check("t2_gap", gap_seen, 1);
        check("t2_no_err", err_cnt, 0);

        // 40-character string truncated to 32, then a pattern
        err_cnt = 0;
        for (int i = 0; i < 40; i++) put(8'(8'h30 + i), 0, (i == 39), (i < 32));
        put("x", 1, 1, 1);
        in_valid = 0;
        wait_done("t3");
        check("t3_err_pulses", err_cnt, 1);

        // Orphan pattern right after reset, then prove the FIFO is clean
        do_reset();
        err_cnt = 0;
        put("z", 1, 0, 0); put("z", 1, 1, 0);
        in_valid = 0;
        wait_done("t4_drain");
        check("t4_err_pulses", err_cnt, 1);
        put("q", 0, 1, 1); put("r", 1, 1, 1);
        in_valid = 0;
        wait_done("t4_clean");
        check("t4_err_unchanged", err_cnt, 1);

        // Fill the FIFO while WAIT_RES holds off reads
        auto_resp = 0; gap_seen = 0;
        put("s", 0, 1, 1); put("p", 1, 1, 1);
        in_valid = 0;
        wait_gap("t5_gap");
        k = 0;
        for (int r = 0; r < 6; r++) begin
            for (int j = 0; j < rec_len[r]; j++) begin
                ent_t e;
                e.d = 8'(k * 7 + 3);
                e.t = r[0];
                e.l = (j == rec_len[r] - 1);
                fill_q.push_back(e);
                k++;
            end
        end
        k = 0; accepted = 0; g = 0; full_seen = 0;
        in_valid = 1;
        while (k < fill_q.size() && g < 5000) begin
            in_data = fill_q[k].d; in_type = fill_q[k].t; in_last = fill_q[k].l;
            if (in_ready) begin
                sb.push_back({~fill_q[k].t, fill_q[k].t, fill_q[k].d});
                k++;
                accepted++;
                step();
            end else if (!full_seen) begin
                full_seen = 1;
                check("t5_full_at", accepted, 64);
                repeat (4) step();
                check("t5_stays_full", in_ready, 0);
                sme_valid = 1;
                step();
                check("t5_ready_before_pop", in_ready, 0);
                step();
                check("t5_ready_after_pop", {in_ready, isstring, chardata}, {1'b1, 1'b1, fill_q[0].d});
                auto_resp = 1;
            end else begin
                step();
            end
            g++;
        end
        in_valid = 0;
        check("t5_all_accepted", k, fill_q.size());
        check("t5_full_seen", full_seen, 1);
        wait_done("t5");

        // Reset asserted during SEND
        auto_resp = 1;
        put("a", 0, 0, 1); put("b", 0, 0, 1); put("c", 0, 0, 1); put("d", 0, 1, 1);
        put("e", 1, 0, 1); put("f", 1, 1, 1);
        in_valid = 0;
        g = 0;
        while (!isstring && g < 50) begin
            step();
            g++;
        end
        check("t6_sending", isstring, 1);
        reset = 1;
        sb.delete();
        prev_str = 0; prev_pat = 0; resp_cnt = 0;
        #1;
        check("t6_in_ready_in_reset", in_ready, 0);
        step();
        check("t6_isstring_idle", isstring, 0);
        check("t6_ispattern_idle", ispattern, 0);
        check("t6_busy_idle", busy, 0);
        reset = 0;
        #1;
        check("t6_in_ready_after", in_ready, 1);
        repeat (10) step();
        check("t6_stays_idle", busy, 0);

`ifdef SME_LDR_TIMEOUT_EN
        // No result ever returned: timeout after 255 WAIT_RES cycles
        auto_resp = 0; gap_seen = 0; err_cnt = 0;
        put("t", 0, 1, 1); put("u", 1, 1, 1);
        in_valid = 0;
        wait_gap("t7_gap");
        g = 0;
        while (!err && g < 400) begin
            step();
            g++;
        end
        check("t7_timeout_cycle", g, 255);
        check("t7_busy_after_timeout", busy, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
